// File: rtl/fifo_word_packer.sv
// Packs pairs of FIFO words into one double-width output word, first word in the low half.
// A flush emits a held odd word zero-padded in the high half, flagged by out_half.
module fifo_word_packer #(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FIFO_WIDTH-1:0]   fifo_data_out,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic                    flush,
    output logic [2*FIFO_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_half,
    output logic                    flush_done
);

    logic                  pend;
    logic                  have_lo;
    logic [FIFO_WIDTH-1:0] lo_reg;
    logic                  flush_req;

    logic out_free;
    logic pair_load;
    logic flush_eval;
    logic partial_load;
    logic flush_finish;

    // A read is never issued while the second word of a pair is in flight, so the
    // output register is always free when a pair completes.
    always_comb begin
        out_free     = !out_valid || out_ready;
        pair_load    = pend && have_lo;
        flush_eval   = flush_req && !pend;
        partial_load = flush_eval && have_lo && out_free;
        flush_finish = flush_eval && (!have_lo || out_free);
        fifo_rd_en   = !rst && !fifo_empty && !flush_req && out_free && !(pend && have_lo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= 1'b0;
            have_lo    <= 1'b0;
            lo_reg     <= '0;
            flush_req  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_half   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            pend       <= fifo_rd_en;
            flush_done <= flush_finish;

            if (pend && !have_lo) begin
                lo_reg  <= fifo_data_out;
                have_lo <= 1'b1;
            end else if (pair_load || partial_load) begin
                have_lo <= 1'b0;
            end

            // An in-flight word always settles before a pending flush is acted on.
            if (flush_finish) begin
                flush_req <= 1'b0;
            end else if (flush && !flush_req) begin
                flush_req <= 1'b1;
            end

            if (pair_load) begin
                out_data  <= {fifo_data_out, lo_reg};
                out_valid <= 1'b1;
                out_half  <= 1'b0;
            end else if (partial_load) begin
                out_data  <= {{FIFO_WIDTH{1'b0}}, lo_reg};
                out_valid <= 1'b1;
                out_half  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a behavioural FIFO feeds the DUT and a
// negedge monitor checks every accepted output word against queued expectations.
module tb_fifo_word_packer;

    localparam int W = 16;

    typedef struct {
        logic [2*W-1:0] data;
        logic           half;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   fifo_data_out = '0;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic           flush = 1'b0;
    logic [2*W-1:0] out_data;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_half;
    logic           flush_done;

    logic [W-1:0] mem [0:2047];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic         stall = 1'b0;

    exp_t exp_q[$];
    int   assert_cnt = 0;
    int   fail_cnt = 0;
    int   flush_done_cnt = 0;

    fifo_word_packer #(.FIFO_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_half     (out_half),
        .flush_done   (flush_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr) || stall;

    // Behavioural FIFO: read data appears the cycle after fifo_rd_en.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data_out <= mem[rd_ptr % 2048];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] word);
        mem[wr_ptr % 2048] = word;
        wr_ptr++;
    endtask

    task automatic expect_word(input logic [2*W-1:0] data, input logic half);
        exp_t e;
        e.data = data;
        e.half = half;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput({name, "_drain_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_fifo_empty(input string name, input int budget);
        int n;
        n = 0;
        while (rd_ptr != wr_ptr && n < budget) begin
            tick();
            n++;
        end
        checkOutput({name, "_fifo_not_drained"}, 64'(wr_ptr - rd_ptr), 64'd0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Monitor: pops one expectation per accepted word, checks reads and counts flush_done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            checkOutput("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
        end else begin
            if (fifo_rd_en) checkOutput("rd_en_while_empty", 64'(fifo_empty), 64'd0);
            if (flush_done) flush_done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", 64'(out_data), 64'(e.data));
                    checkOutput("out_half", 64'(out_half), 64'(e.half));
                end
            end
        end
    end

    initial begin
        int fd_start;
        int n;

        // Reset with a non-empty FIFO: no reads may be issued.
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        applyStimulus(16'h3333);
        applyStimulus(16'h4444);
        tick();
        tick();
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_half", 64'(out_half), 64'd0);
        checkOutput("reset_flush_done", 64'(flush_done), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_rd_en", 64'(fifo_rd_en), 64'd0);

        // Four words, always ready.
        expect_word(32'h2222_1111, 1'b0);
        expect_word(32'h4444_3333, 1'b0);
        rst = 1'b0;
        wait_drain("basic", 50);
        repeat (3) tick();

        // Odd word count followed by a flush issued as the last read goes out.
        fd_start = flush_done_cnt;
        expect_word(32'hBBBB_AAAA, 1'b0);
        expect_word(32'h0000_CCCC, 1'b1);
        applyStimulus(16'hAAAA);
        applyStimulus(16'hBBBB);
        applyStimulus(16'hCCCC);
        wait_fifo_empty("flush3", 50);
        pulse_flush();
        wait_drain("flush3", 50);
        repeat (4) tick();
        checkOutput("flush3_done_pulses", 64'(flush_done_cnt - fd_start), 64'd1);

        // Back-pressure: output word must hold still and no reads issued.
        out_ready = 1'b0;
        expect_word(32'h5678_1234, 1'b0);
        expect_word(32'hDEF0_9ABC, 1'b0);
        applyStimulus(16'h1234);
        applyStimulus(16'h5678);
        applyStimulus(16'h9ABC);
        applyStimulus(16'hDEF0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_out_data", 64'(out_data), 64'h5678_1234);
            checkOutput("stall_rd_en", 64'(fifo_rd_en), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        wait_drain("stall", 50);
        repeat (3) tick();

        // Flush with nothing held.
        fd_start = flush_done_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("idle_flush_done_early", 64'(flush_done), 64'd0);
        tick();
        checkOutput("idle_flush_done", 64'(flush_done), 64'd1);
        checkOutput("idle_flush_valid", 64'(out_valid), 64'd0);
        tick();
        checkOutput("idle_flush_done_clear", 64'(flush_done), 64'd0);
        checkOutput("idle_flush_valid2", 64'(out_valid), 64'd0);
        repeat (2) tick();
        checkOutput("idle_flush_pulses", 64'(flush_done_cnt - fd_start), 64'd1);

        // Flush landing on the same edge that a pair completes.
        fd_start = flush_done_cnt;
        expect_word(32'hEEEE_DDDD, 1'b0);
        applyStimulus(16'hDDDD);
        applyStimulus(16'hEEEE);
        n = 0;
        @(negedge clk);
        while (!(fifo_rd_en && (wr_ptr - rd_ptr) == 1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pairflush_sync_timeout", 64'(n < 20), 64'd1);
        tick();
        pulse_flush();
        wait_drain("pairflush", 50);
        repeat (4) tick();
        checkOutput("pairflush_pulses", 64'(flush_done_cnt - fd_start), 64'd1);

        // Reset the cycle after a single read; the held word must vanish.
        applyStimulus(16'h5555);
        n = 0;
        @(negedge clk);
        while (!fifo_rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midreset_sync_timeout", 64'(n < 20), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_out_data", 64'(out_data), 64'd0);
        checkOutput("midreset_out_half", 64'(out_half), 64'd0);
        checkOutput("midreset_flush_done", 64'(flush_done), 64'd0);
        expect_word(32'h7777_6666, 1'b0);
        applyStimulus(16'h6666);
        applyStimulus(16'h7777);
        wait_drain("midreset", 50);
        repeat (3) tick();

        // Random back-pressure and empty stalls over 1001 words, flush at the end.
        fd_start = flush_done_cnt;
        for (int i = 0; i < 1000; i += 2)
            expect_word({16'(16'h1000 + i + 1), 16'(16'h1000 + i)}, 1'b0);
        expect_word({16'h0000, 16'(16'h1000 + 1000)}, 1'b1);
        for (int i = 0; i < 1001; i++)
            applyStimulus(16'(16'h1000 + i));
        n = 0;
        while (rd_ptr != wr_ptr && n < 12000) begin
            out_ready = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        stall = 1'b0;
        out_ready = 1'b1;
        wait_fifo_empty("random", 50);
        tick();
        pulse_flush();
        wait_drain("random", 200);
        repeat (4) tick();
        checkOutput("random_flush_pulses", 64'(flush_done_cnt - fd_start), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
